// File: rtl/mem_access_sequencer_pkg.sv
// Shared definitions for the load/store/swap memory access sequencer.
// Holds the FSM state encoding, op3 codes, RAM word opcodes, the registered
// control-output bundle and the op-class decode that the control unit also uses.
package mem_seq_pkg;

    localparam int unsigned OP3_W   = 6;
    localparam int unsigned STATE_W = 4;

    // Sequencer states (11 used codes of a 4-bit register)
    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 4'd0,
        S_ADDR   = 4'd1,
        S_RD_REQ = 4'd2,
        S_RD_CAP = 4'd3,
        S_WB     = 4'd4,
        S_WR_LD  = 4'd5,
        S_WR_REQ = 4'd6,
        S_SW_TMP = 4'd7,
        S_SW_WB  = 4'd8,
        S_DONE   = 4'd9,
        S_ERR    = 4'd10
    } state_e;

    // op3 codes handled by the sequencer
    localparam logic [OP3_W-1:0] OP_LD   = 6'b000000;
    localparam logic [OP3_W-1:0] OP_LDUB = 6'b000001;
    localparam logic [OP3_W-1:0] OP_LDUH = 6'b000010;
    localparam logic [OP3_W-1:0] OP_LDD  = 6'b000011;
    localparam logic [OP3_W-1:0] OP_ST   = 6'b000100;
    localparam logic [OP3_W-1:0] OP_STB  = 6'b000101;
    localparam logic [OP3_W-1:0] OP_STH  = 6'b000110;
    localparam logic [OP3_W-1:0] OP_STD  = 6'b000111;
    localparam logic [OP3_W-1:0] OP_LDSB = 6'b001001;
    localparam logic [OP3_W-1:0] OP_LDSH = 6'b001010;
    localparam logic [OP3_W-1:0] OP_SWAP = 6'b001111;

    // Word-sized RAM opcodes used by the split/compound accesses
    localparam logic [OP3_W-1:0] RAM_OP_RD_WORD = OP_LD;
    localparam logic [OP3_W-1:0] RAM_OP_WR_WORD = OP_ST;

    typedef enum logic [2:0] {
        CLS_LD,
        CLS_LDD,
        CLS_ST,
        CLS_STD,
        CLS_SWAP,
        CLS_ILLEGAL
    } op_cls_e;

    // Registered control outputs driven to the datapath and RAM
    typedef struct packed {
        logic             mar_en;
        logic             mdr_en;
        logic             mdr_mux_sel;
        logic             ram_en;
        logic [OP3_W-1:0] ram_opcode;
        logic             rf_we;
        logic             temp_en;
        logic             wb_src;
        logic             busy;
        logic             done;
        logic             mem_error;
    } ctl_t;

    // Classify an op3 value into the access sequence it needs
    function automatic op_cls_e op_class(input logic [OP3_W-1:0] op3);
        op_cls_e cls;
        case (op3)
            OP_LD, OP_LDUB, OP_LDUH, OP_LDSB, OP_LDSH: cls = CLS_LD;
            OP_LDD:                                    cls = CLS_LDD;
            OP_ST, OP_STB, OP_STH:                     cls = CLS_ST;
            OP_STD:                                    cls = CLS_STD;
            OP_SWAP:                                   cls = CLS_SWAP;
            default:                                   cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_mfc_wait_timer.sv
// MFC wait timer: counts cycles spent waiting for MFC in a RAM request state.
// Ports: clk/rst (async, active-high); clr zeroes the count; en counts one
// waiting cycle; expired_c is high in the waiting cycle that reaches the limit.
module mfc_wait_timer #(
    parameter int unsigned MFC_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(MFC_TIMEOUT + 1);
    // Count value seen in the last allowed waiting cycle
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MFC_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The increment this cycle would reach MFC_TIMEOUT
    assign expired_c = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mem_access_sequencer.sv
// Memory access sequencer for op=2'b11 load/store/swap instructions.
// Ports: Clk, RESET (async, active-high); start/op3/rd_lsb from the control
// unit; MFC from RAM; MAR/MDR/TEMP/regfile strobes, RAM request and opcode,
// word_sel for ldd/std halves, busy, done and mem_error status.
// All outputs are registered decodes of the next state.
module mem_access_sequencer
    import mem_seq_pkg::*;
#(
    parameter int unsigned MFC_TIMEOUT = 15
) (
    input  logic             Clk,
    input  logic             RESET,
    input  logic             start,
    input  logic [OP3_W-1:0] op3,
    input  logic             rd_lsb,
    input  logic             MFC,
    output logic             MAR_Enable,
    output logic             MDR_Enable,
    output logic             MDR_Mux_select,
    output logic             RAM_enable,
    output logic [OP3_W-1:0] RAM_OpCode,
    output logic             register_file,
    output logic             TEMP_Enable,
    output logic             wb_src,
    output logic             word_sel,
    output logic             busy,
    output logic             done,
    output logic             mem_error
);

    state_e           state_q, state_d;
    logic [OP3_W-1:0] op3_q, op3_d;
    logic             word_sel_q, word_sel_d;
    ctl_t             ctl_q, ctl_d;

    op_cls_e start_cls;
    op_cls_e cur_cls;
    logic    in_req;
    logic    timeout_c;

    assign start_cls = op_class(op3);
    assign cur_cls   = op_class(op3_q);
    assign in_req    = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);

    // Wait count restarts whenever the FSM is outside a request state
    mfc_wait_timer #(
        .MFC_TIMEOUT(MFC_TIMEOUT)
    ) u_mfc_wait_timer (
        .clk      (Clk),
        .rst      (RESET),
        .clr      (!in_req),
        .en       (in_req && !MFC),
        .expired_c(timeout_c)
    );

    // Next state, latched instruction fields and registered output decode
    always_comb begin
        state_d    = state_q;
        op3_d      = op3_q;
        word_sel_d = word_sel_q;
        ctl_d      = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op3_d = op3;
                    if ((start_cls == CLS_ILLEGAL) ||
                        (((start_cls == CLS_LDD) || (start_cls == CLS_STD)) && rd_lsb)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                case (cur_cls)
                    CLS_LD, CLS_LDD, CLS_SWAP: state_d = S_RD_REQ;
                    CLS_ST, CLS_STD:           state_d = S_WR_LD;
                    default:                   state_d = S_ERR;
                endcase
            end
            S_RD_REQ: begin
                // MFC wins over a coincident timeout
                if (MFC) begin
                    state_d = S_RD_CAP;
                end else if (timeout_c) begin
                    state_d = S_ERR;
                end
            end
            S_RD_CAP: begin
                state_d = (cur_cls == CLS_SWAP) ? S_SW_TMP : S_WB;
            end
            S_WB: begin
                if ((cur_cls == CLS_LDD) && !word_sel_q) begin
                    word_sel_d = 1'b1;
                    state_d    = S_ADDR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_WR_LD: begin
                state_d = S_WR_REQ;
            end
            S_WR_REQ: begin
                if (MFC) begin
                    if (cur_cls == CLS_SWAP) begin
                        state_d = S_SW_WB;
                    end else if ((cur_cls == CLS_STD) && !word_sel_q) begin
                        word_sel_d = 1'b1;
                        state_d    = S_ADDR;
                    end else begin
                        state_d = S_DONE;
                    end
                end else if (timeout_c) begin
                    state_d = S_ERR;
                end
            end
            S_SW_TMP: begin
                state_d = S_WR_LD;
            end
            S_SW_WB: begin
                state_d = S_DONE;
            end
            S_DONE, S_ERR: begin
                state_d    = S_IDLE;
                word_sel_d = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                word_sel_d = 1'b0;
            end
        endcase

        ctl_d.mar_en      = (state_d == S_ADDR);
        ctl_d.mdr_en      = (state_d == S_RD_CAP) || (state_d == S_WR_LD);
        ctl_d.mdr_mux_sel = (state_d == S_RD_REQ) || (state_d == S_RD_CAP);
        ctl_d.ram_en      = (state_d == S_RD_REQ) || (state_d == S_WR_REQ);
        ctl_d.rf_we       = (state_d == S_WB) || (state_d == S_SW_WB);
        ctl_d.temp_en     = (state_d == S_SW_TMP);
        ctl_d.wb_src      = (state_d == S_SW_WB);
        ctl_d.busy        = (state_d != S_IDLE);
        ctl_d.done        = (state_d == S_DONE) || (state_d == S_ERR);
        ctl_d.mem_error   = (state_d == S_ERR);

        // Sub-word ops pass through; compound ops use whole-word accesses
        if (state_d == S_RD_REQ) begin
            ctl_d.ram_opcode = (cur_cls == CLS_LD) ? op3_q : RAM_OP_RD_WORD;
        end else if (state_d == S_WR_REQ) begin
            ctl_d.ram_opcode = (cur_cls == CLS_ST) ? op3_q : RAM_OP_WR_WORD;
        end
    end

    // State, instruction latch and output registers
    always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            op3_q      <= '0;
            word_sel_q <= 1'b0;
            ctl_q      <= '0;
        end else begin
            state_q    <= state_d;
            op3_q      <= op3_d;
            word_sel_q <= word_sel_d;
            ctl_q      <= ctl_d;
        end
    end

    assign MAR_Enable     = ctl_q.mar_en;
    assign MDR_Enable     = ctl_q.mdr_en;
    assign MDR_Mux_select = ctl_q.mdr_mux_sel;
    assign RAM_enable     = ctl_q.ram_en;
    assign RAM_OpCode     = ctl_q.ram_opcode;
    assign register_file  = ctl_q.rf_we;
    assign TEMP_Enable    = ctl_q.temp_en;
    assign wb_src         = ctl_q.wb_src;
    assign word_sel       = word_sel_q;
    assign busy           = ctl_q.busy;
    assign done           = ctl_q.done;
    assign mem_error      = ctl_q.mem_error;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed and randomized
// transactions, each predicted from op class and MFC delay by arithmetic.
module tb_mem_access_sequencer;

    localparam int TMO = 15;

    logic       Clk;
    logic       RESET;
    logic       start;
    logic [5:0] op3;
    logic       rd_lsb;
    logic       MFC;
    logic       MAR_Enable;
    logic       MDR_Enable;
    logic       MDR_Mux_select;
    logic       RAM_enable;
    logic [5:0] RAM_OpCode;
    logic       register_file;
    logic       TEMP_Enable;
    logic       wb_src;
    logic       word_sel;
    logic       busy;
    logic       done;
    logic       mem_error;

    int n_chk = 0;
    int n_bad = 0;
    int mfc_delay = 0;
    bit mfc_noise = 1'b0;

    mem_access_sequencer #(.MFC_TIMEOUT(TMO)) dut (
        .Clk           (Clk),
        .RESET         (RESET),
        .start         (start),
        .op3           (op3),
        .rd_lsb        (rd_lsb),
        .MFC           (MFC),
        .MAR_Enable    (MAR_Enable),
        .MDR_Enable    (MDR_Enable),
        .MDR_Mux_select(MDR_Mux_select),
        .RAM_enable    (RAM_enable),
        .RAM_OpCode    (RAM_OpCode),
        .register_file (register_file),
        .TEMP_Enable   (TEMP_Enable),
        .wb_src        (wb_src),
        .word_sel      (word_sel),
        .busy          (busy),
        .done          (done),
        .mem_error     (mem_error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // RAM responder: MFC after mfc_delay waiting cycles of each request
    initial begin
        int age;
        age = 0;
        MFC = 1'b0;
        forever begin
            @(negedge Clk);
            if (RAM_enable) begin
                MFC = (age >= mfc_delay);
                age++;
            end else begin
                age = 0;
                MFC = mfc_noise ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return 32'({MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
                    register_file, TEMP_Enable, wb_src, word_sel, busy, done, mem_error});
    endfunction

    // One transaction: predict from the op-class rules, observe, compare
    task automatic run_txn(input logic [5:0] op, input logic lsb, input int d, input bit noise);
        int    nreq, base, pre;
        int    e_mar, e_mdr, e_rd, e_rf, e_tmp, e_wb1, e_done, e_ram, e_err;
        int    n_mar, n_mdr, n_rd, n_rf, n_tmp, n_wb1, n_ram;
        int    onehot_bad, busy_bad, err_alone, op_glitch, done_at, err_seen;
        int    eops[$];
        int    ews[$];
        int    gops[$];
        int    gws[$];
        bit    ram_prev, got_done;
        string lbl;

        lbl = $sformatf("op=%b lsb=%0d d=%0d", op, lsb, d);
        nreq = 0; base = 0; pre = 0;
        e_mar = 0; e_mdr = 0; e_rd = 0; e_rf = 0; e_tmp = 0; e_wb1 = 0; e_ram = 0; e_err = 0;
        if (op inside {6'b000000, 6'b000001, 6'b000010, 6'b001001, 6'b001010}) begin
            nreq = 1; base = 5; pre = 1; e_mar = 1; e_mdr = 1; e_rd = 1; e_rf = 1;
            eops.push_back(int'(op)); ews.push_back(0);
        end else if (op inside {6'b000100, 6'b000101, 6'b000110}) begin
            nreq = 1; base = 4; pre = 2; e_mar = 1; e_mdr = 1;
            eops.push_back(int'(op)); ews.push_back(0);
        end else if (op == 6'b000011 && !lsb) begin
            nreq = 2; base = 9; pre = 1; e_mar = 2; e_mdr = 2; e_rd = 2; e_rf = 2;
            eops.push_back(0); eops.push_back(0); ews.push_back(0); ews.push_back(1);
        end else if (op == 6'b000111 && !lsb) begin
            nreq = 2; base = 7; pre = 2; e_mar = 2; e_mdr = 2;
            eops.push_back(4); eops.push_back(4); ews.push_back(0); ews.push_back(1);
        end else if (op == 6'b001111) begin
            nreq = 2; base = 8; pre = 1; e_mar = 1; e_mdr = 2; e_rd = 1; e_rf = 1;
            e_tmp = 1; e_wb1 = 1;
            eops.push_back(0); eops.push_back(4); ews.push_back(0); ews.push_back(0);
        end

        if (nreq == 0) begin
            e_done = 1; e_err = 1;
        end else if (d >= TMO) begin
            // First request times out: no data moves beyond the write-side MDR load
            e_done = pre + TMO + 1; e_ram = TMO; e_err = 1; e_mar = 1;
            e_mdr = (pre == 2) ? 1 : 0; e_rd = 0; e_rf = 0; e_tmp = 0; e_wb1 = 0;
            while (eops.size() > 1) void'(eops.pop_back());
            while (ews.size() > 1) void'(ews.pop_back());
        end else begin
            e_done = base + nreq * d;
            e_ram = nreq * (d + 1);
        end

        n_mar = 0; n_mdr = 0; n_rd = 0; n_rf = 0; n_tmp = 0; n_wb1 = 0; n_ram = 0;
        onehot_bad = 0; busy_bad = 0; err_alone = 0; op_glitch = 0; done_at = 0; err_seen = 0;
        ram_prev = 1'b0; got_done = 1'b0;

        @(negedge Clk);
        start = 1'b1; op3 = op; rd_lsb = lsb; mfc_delay = d; mfc_noise = noise;
        @(negedge Clk);
        for (int cyc = 1; cyc <= 120 && !got_done; cyc++) begin
            start = (noise && cyc < e_done) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                op3 = 6'($urandom);
                rd_lsb = 1'($urandom_range(0, 1));
            end
            n_mar += int'(MAR_Enable);
            n_mdr += int'(MDR_Enable);
            n_rd  += int'(MDR_Enable && MDR_Mux_select);
            n_rf  += int'(register_file);
            n_tmp += int'(TEMP_Enable);
            n_wb1 += int'(register_file && wb_src);
            if (int'(MAR_Enable) + int'(MDR_Enable) + int'(register_file) + int'(TEMP_Enable) > 1)
                onehot_bad++;
            if (!busy) busy_bad++;
            if (mem_error && !done) err_alone++;
            if (RAM_enable) begin
                n_ram++;
                if (!ram_prev) begin
                    gops.push_back(int'(RAM_OpCode));
                    gws.push_back(int'(word_sel));
                end else if (int'(RAM_OpCode) != gops[$]) begin
                    op_glitch++;
                end
            end
            ram_prev = RAM_enable;
            if (done) begin
                got_done = 1'b1;
                done_at = cyc;
                err_seen = int'(mem_error);
            end
            @(negedge Clk);
        end
        start = 1'b0;

        chk({lbl, " done_cycle"}, done_at, e_done);
        chk({lbl, " mem_error"}, err_seen, e_err);
        chk({lbl, " mar_pulses"}, n_mar, e_mar);
        chk({lbl, " mdr_pulses"}, n_mdr, e_mdr);
        chk({lbl, " mdr_from_ram"}, n_rd, e_rd);
        chk({lbl, " regfile_pulses"}, n_rf, e_rf);
        chk({lbl, " temp_pulses"}, n_tmp, e_tmp);
        chk({lbl, " wb_from_temp"}, n_wb1, e_wb1);
        chk({lbl, " ram_cycles"}, n_ram, e_ram);
        chk({lbl, " strobe_overlap"}, onehot_bad, 0);
        chk({lbl, " busy_low_in_txn"}, busy_bad, 0);
        chk({lbl, " error_without_done"}, err_alone, 0);
        chk({lbl, " opcode_changed_in_req"}, op_glitch, 0);
        chk({lbl, " num_requests"}, gops.size(), eops.size());
        for (int i = 0; i < eops.size(); i++) begin
            chk($sformatf("%s req%0d opcode", lbl, i), (i < gops.size()) ? gops[i] : -1, eops[i]);
            chk($sformatf("%s req%0d word_sel", lbl, i), (i < gws.size()) ? gws[i] : -1, ews[i]);
        end
        chk({lbl, " idle_after_done"}, out_vec(), 0);
    endtask

    function automatic logic [5:0] pick_op(input int sel);
        case (sel)
            0:  return 6'b000000;
            1:  return 6'b000001;
            2:  return 6'b000010;
            3:  return 6'b001001;
            4:  return 6'b001010;
            5:  return 6'b000011;
            6:  return 6'b000100;
            7:  return 6'b000101;
            8:  return 6'b000110;
            9:  return 6'b000111;
            10: return 6'b001111;
            11: return 6'b111111;
            default: return 6'($urandom);
        endcase
    endfunction

    function automatic int pick_delay(input int sel);
        case (sel)
            0, 1, 2: return 0;
            3:       return 1;
            4:       return 2;
            5:       return 3;
            6:       return TMO - 1;
            7:       return TMO;
            default: return TMO + 7;
        endcase
    endfunction

    initial begin
        RESET = 1'b0; start = 1'b0; op3 = '0; rd_lsb = 1'b0;
        #1 RESET = 1'b1;
        #1 chk("reset_outputs", out_vec(), 0);
        @(negedge Clk);
        @(negedge Clk);
        RESET = 1'b0;

        run_txn(6'b000000, 1'b0, 1, 1'b0);      // LD with one wait
        run_txn(6'b000100, 1'b0, 0, 1'b0);      // ST immediate
        run_txn(6'b000011, 1'b0, 0, 1'b0);      // LDD two passes
        run_txn(6'b000011, 1'b1, 0, 1'b0);      // LDD misaligned
        run_txn(6'b001111, 1'b0, 0, 1'b0);      // SWAP
        run_txn(6'b000000, 1'b0, 100, 1'b0);    // read timeout
        run_txn(6'b111111, 1'b0, 0, 1'b0);      // illegal op
        run_txn(6'b000111, 1'b0, 0, 1'b0);      // STD two passes
        run_txn(6'b000111, 1'b1, 0, 1'b0);      // STD misaligned
        run_txn(6'b000001, 1'b0, TMO - 1, 1'b0); // MFC on the limit cycle
        run_txn(6'b000101, 1'b0, TMO, 1'b0);    // write timeout

        // Reset in the middle of a write request
        @(negedge Clk);
        start = 1'b1; op3 = 6'b000100; rd_lsb = 1'b0; mfc_delay = 100;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("pre_reset_in_write_request", {30'd0, RAM_enable, busy}, 32'd3);
        #2 RESET = 1'b1;
        #1 chk("async_reset_outputs", out_vec(), 0);
        @(negedge Clk);
        RESET = 1'b0;
        run_txn(6'b000100, 1'b0, 2, 1'b0);

        for (int k = 0; k < 40; k++) begin
            run_txn(pick_op($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                    pick_delay($urandom_range(0, 8)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
